// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer allocation controller: head/tail/occupancy tracking, 4-wide dispatch grants,
// commit retirement and branch-flush rollback followed by a short dispatch-blocked recovery window.
module rob_alloc_ctrl #(
  parameter int DEPTH       = 128,
  parameter int IDX_W       = 7,
  parameter int WIDTH       = 4,
  parameter int RECOVER_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] disp_valid,
  output logic             disp_ready,
  output logic [WIDTH-1:0] alloc_mask,
  output logic [IDX_W-1:0] alloc_idx0,
  output logic [IDX_W-1:0] alloc_idx1,
  output logic [IDX_W-1:0] alloc_idx2,
  output logic [IDX_W-1:0] alloc_idx3,
  input  logic [2:0]       commit_num,
  input  logic             flush_req,
  input  logic [IDX_W-1:0] flush_idx,
  output logic [IDX_W-1:0] head_idx,
  output logic [IDX_W-1:0] tail_idx,
  output logic [IDX_W:0]   occupancy,
  output logic             full,
  output logic             empty,
  output logic             recovering,
  output logic             proto_err
);

  localparam int OCC_W = IDX_W + 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int REC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam logic [REC_W-1:0] REC_INIT = REC_W'(RECOVER_CYC - 1);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t           state;
  logic [REC_W-1:0] rec_cnt;

  logic [CNT_W-1:0] run_len;
  logic             run_broken;
  logic [CNT_W-1:0] n_disp;
  logic             space_ok;

  logic [IDX_W-1:0] flush_dist;
  logic             flush_legal;
  logic [OCC_W-1:0] keep_cnt;
  logic [OCC_W-1:0] commit_ext;
  logic [2:0]       commit_clip;
  logic [2:0]       eff_commit;
  logic             commit_bad;

  // Only the unbroken run of requests starting at lane 0 is eligible for a grant.
  always_comb begin
    run_len    = '0;
    run_broken = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!disp_valid[i]) run_broken = 1'b1;
      else if (!run_broken) run_len = run_len + CNT_W'(1);
    end
  end

  assign space_ok   = (occupancy <= OCC_W'(DEPTH - WIDTH));
  assign disp_ready = reset && (state == RUN) && !flush_req && space_ok;
  assign n_disp     = disp_ready ? run_len : '0;

  always_comb begin
    alloc_mask = '0;
    for (int i = 0; i < WIDTH; i++) alloc_mask[i] = (n_disp > CNT_W'(i));
  end

  assign alloc_idx0 = tail_idx;
  assign alloc_idx1 = tail_idx + IDX_W'(1);
  assign alloc_idx2 = tail_idx + IDX_W'(2);
  assign alloc_idx3 = tail_idx + IDX_W'(3);

  // A flush is only honoured when its survivor index lies inside the live window.
  assign flush_dist  = flush_idx - head_idx;
  assign flush_legal = flush_req && (OCC_W'(flush_dist) < occupancy);
  assign keep_cnt    = OCC_W'(flush_dist) + OCC_W'(1);

  // Commit cannot retire more than is live, nor past the flush survivor.
  assign commit_ext  = OCC_W'(commit_num);
  assign commit_clip = (commit_ext > occupancy) ? occupancy[2:0] : commit_num;
  assign eff_commit  = (flush_legal && (OCC_W'(commit_clip) > keep_cnt)) ? keep_cnt[2:0]
                                                                         : commit_clip;
  assign commit_bad  = (commit_ext > OCC_W'(WIDTH)) || (commit_ext > occupancy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_idx  <= '0;
      tail_idx  <= '0;
      occupancy <= '0;
      state     <= RUN;
      rec_cnt   <= '0;
      proto_err <= 1'b0;
    end else begin
      head_idx <= head_idx + IDX_W'(eff_commit);
      if (flush_legal) begin
        tail_idx  <= flush_idx + IDX_W'(1);
        occupancy <= keep_cnt - OCC_W'(eff_commit);
      end else begin
        tail_idx  <= tail_idx + IDX_W'(n_disp);
        occupancy <= occupancy + OCC_W'(n_disp) - OCC_W'(eff_commit);
      end
      if (commit_bad || (flush_req && !flush_legal)) proto_err <= 1'b1;
      case (state)
        RUN: begin
          if (flush_legal) begin
            state   <= RECOVER;
            rec_cnt <= REC_INIT;
          end
        end
        RECOVER: begin
          if (flush_legal) rec_cnt <= REC_INIT;
          else if (rec_cnt == '0) state <= RUN;
          else rec_cnt <= rec_cnt - REC_W'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

  assign full       = (occupancy == OCC_W'(DEPTH));
  assign empty      = (occupancy == '0);
  assign recovering = (state == RECOVER);

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed self-checking bench for rob_alloc_ctrl: dispatch, wrap-around, fill/drain,
// legal and illegal flushes, recovery window and asynchronous reset.
module tb_rob_alloc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] disp_valid;
  logic       disp_ready;
  logic [3:0] alloc_mask;
  logic [6:0] alloc_idx0, alloc_idx1, alloc_idx2, alloc_idx3;
  logic [2:0] commit_num;
  logic       flush_req;
  logic [6:0] flush_idx;
  logic [6:0] head_idx, tail_idx;
  logic [7:0] occupancy;
  logic       full, empty, recovering, proto_err;

  int total = 0;
  int bad   = 0;

  rob_alloc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .disp_valid (disp_valid),
    .disp_ready (disp_ready),
    .alloc_mask (alloc_mask),
    .alloc_idx0 (alloc_idx0),
    .alloc_idx1 (alloc_idx1),
    .alloc_idx2 (alloc_idx2),
    .alloc_idx3 (alloc_idx3),
    .commit_num (commit_num),
    .flush_req  (flush_req),
    .flush_idx  (flush_idx),
    .head_idx   (head_idx),
    .tail_idx   (tail_idx),
    .occupancy  (occupancy),
    .full       (full),
    .empty      (empty),
    .recovering (recovering),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    disp_valid = 4'b1111;
    commit_num = 3'd0;
    flush_req  = 1'b0;
    flush_idx  = 7'd0;

    // Outputs held quiet while reset is low, even with requests pending.
    repeat (2) tick();
    check("rst_ready", disp_ready, 0);
    check("rst_mask", alloc_mask, 0);
    check("rst_occ", occupancy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_proto", proto_err, 0);

    // Three full-width dispatch cycles from reset.
    reset = 1'b1;
    #1;
    check("t1_idx0_a", alloc_idx0, 0);
    check("t1_idx3_a", alloc_idx3, 3);
    check("t1_mask", alloc_mask, 4'b1111);
    check("t1_ready", disp_ready, 1);
    tick();
    check("t1_idx0_b", alloc_idx0, 4);
    tick();
    check("t1_idx0_c", alloc_idx0, 8);
    tick();
    disp_valid = 4'b0000;
    #1;
    check("t1_tail", tail_idx, 12);
    check("t1_occ", occupancy, 12);
    check("t1_ready_end", disp_ready, 1);

    // Bring occupancy to 125, where a 4-wide group no longer fits.
    disp_valid = 4'b1111;
    repeat (28) tick();
    disp_valid = 4'b0001;
    tick();
    disp_valid = 4'b1111;
    #1;
    check("t2_occ125", occupancy, 125);
    check("t2_ready", disp_ready, 0);
    check("t2_mask", alloc_mask, 0);
    commit_num = 3'd4;
    tick();
    disp_valid = 4'b0000;
    commit_num = 3'd0;
    #1;
    check("t2_occ121", occupancy, 121);
    check("t2_head", head_idx, 4);
    check("t2_ready_back", disp_ready, 1);

    // Fill to capacity: head == tail with occupancy 128 means full.
    disp_valid = 4'b0111;
    tick();
    check("t6_tail_wrap", tail_idx, 0);
    disp_valid = 4'b1111;
    tick();
    disp_valid = 4'b0000;
    #1;
    check("t6_occ", occupancy, 128);
    check("t6_full", full, 1);
    check("t6_empty", empty, 0);
    check("t6_tail", tail_idx, 4);
    check("t6_ready", disp_ready, 0);
    tick();
    check("t6_full_hold", full, 1);

    // Drain everything: head == tail with occupancy 0 means empty.
    commit_num = 3'd4;
    repeat (32) tick();
    commit_num = 3'd0;
    #1;
    check("drain_empty", empty, 1);
    check("drain_head", head_idx, 4);

    // Walk both pointers to 126 for the wrap-around dispatch.
    disp_valid = 4'b0011;
    tick();
    disp_valid = 4'b1111;
    commit_num = 3'd2;
    tick();
    commit_num = 3'd4;
    repeat (29) tick();
    disp_valid = 4'b0000;
    tick();
    commit_num = 3'd0;
    disp_valid = 4'b1111;
    #1;
    check("t3_head", head_idx, 126);
    check("t3_tail", tail_idx, 126);
    check("t3_occ0", occupancy, 0);
    check("t3_idx0", alloc_idx0, 126);
    check("t3_idx1", alloc_idx1, 127);
    check("t3_idx2", alloc_idx2, 0);
    check("t3_idx3", alloc_idx3, 1);
    tick();
    check("t3_tail_after", tail_idx, 2);
    check("t3_occ_after", occupancy, 4);

    // Set up head=10, occupancy=20 for the flush.
    repeat (7) tick();
    disp_valid = 4'b0000;
    commit_num = 3'd4;
    repeat (3) tick();
    commit_num = 3'd0;
    #1;
    check("t4_pre_head", head_idx, 10);
    check("t4_pre_tail", tail_idx, 30);
    check("t4_pre_occ", occupancy, 20);

    // Legal flush with simultaneous commit, then a two-cycle recovery window.
    disp_valid = 4'b1111;
    flush_req  = 1'b1;
    flush_idx  = 7'd15;
    commit_num = 3'd2;
    #1;
    check("t4_flush_ready", disp_ready, 0);
    check("t4_flush_mask", alloc_mask, 0);
    tick();
    flush_req  = 1'b0;
    commit_num = 3'd0;
    #1;
    check("t4_head", head_idx, 12);
    check("t4_tail", tail_idx, 16);
    check("t4_occ", occupancy, 4);
    check("t4_rec1", recovering, 1);
    check("t4_rec1_ready", disp_ready, 0);
    tick();
    check("t4_rec2", recovering, 1);
    check("t4_rec2_ready", disp_ready, 0);
    check("t4_rec2_occ", occupancy, 4);
    tick();
    disp_valid = 4'b0000;
    check("t4_run", recovering, 0);
    check("t4_run_ready", disp_ready, 1);
    check("t4_proto_clean", proto_err, 0);

    // Flush target outside the live window is rejected and flagged.
    flush_req = 1'b1;
    flush_idx = 7'd40;
    tick();
    flush_req = 1'b0;
    #1;
    check("t5_proto", proto_err, 1);
    check("t5_tail", tail_idx, 16);
    check("t5_occ", occupancy, 4);
    check("t5_head", head_idx, 12);
    check("t5_run", recovering, 0);

    // Only the contiguous request run from lane 0 is granted.
    disp_valid = 4'b0101;
    #1;
    check("run_0101", alloc_mask, 4'b0001);
    check("run_idx0", alloc_idx0, 16);
    disp_valid = 4'b1011;
    #1;
    check("run_1011", alloc_mask, 4'b0011);
    disp_valid = 4'b0111;
    tick();
    disp_valid = 4'b0000;
    #1;
    check("run_tail", tail_idx, 19);
    check("run_occ", occupancy, 7);
    check("proto_sticky", proto_err, 1);

    // Asynchronous reset in the middle of a dispatch cycle.
    disp_valid = 4'b1111;
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_ready", disp_ready, 0);
    check("t6_rst_mask", alloc_mask, 0);
    check("t6_rst_head", head_idx, 0);
    check("t6_rst_tail", tail_idx, 0);
    check("t6_rst_occ", occupancy, 0);
    check("t6_rst_proto", proto_err, 0);
    check("t6_rst_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
